// File: rtl/fp_multiply_pipe_if.sv
// Operand/result handshake bundle for fp_multiply_pipe.
// a_i/b_i/valid_i/ready_o form the input channel, c_o/flags_o/valid_o/ready_i the output channel.
interface fp_multiply_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] c_o;
  logic [3:0]   flags_o;
  logic         valid_o;
  logic         ready_i;

  modport slave (
    input  a_i, b_i, valid_i, ready_i,
    output ready_o, c_o, flags_o, valid_o
  );

  modport master (
    output a_i, b_i, valid_i, ready_i,
    input  ready_o, c_o, flags_o, valid_o
  );
endinterface

// File: rtl/fp_multiply_pipe.sv
// Three-stage floating-point multiplier: classify+multiply, normalise+exponent, round+pack.
// Subnormal inputs are flushed to zero and no subnormal results are produced.
module fp_multiply_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  fp_multiply_pipe_if.slave bus
);
  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * MAN_W + 2;
  localparam logic signed [EW-1:0] BIAS    = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

  typedef enum logic [1:0] {
    CLS_NORM = 2'd0,
    CLS_ZERO = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } cls_e;

  // Handshake: a pair transfers on valid_i & ready_o, a result on valid_o & ready_i.
  // One enable moves the whole pipe; it only freezes when a result is waiting downstream.
  logic en;
  assign en          = ~bus.valid_o | bus.ready_i;
  assign bus.ready_o = en;

  // ---------------- Stage 1: unpack, classify, multiply ----------------
  logic               sa, sb;
  logic [EXP_W-1:0]   ea, eb;
  logic [MAN_W-1:0]   ma, mb;
  logic               a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
  cls_e               cls_n;
  logic               inv_n;
  logic signed [EW-1:0] exp_sum_n;
  logic [PW-1:0]      prod_n;

  assign sa = bus.a_i[EXP_W+MAN_W];
  assign sb = bus.b_i[EXP_W+MAN_W];
  assign ea = bus.a_i[EXP_W+MAN_W-1 -: EXP_W];
  assign eb = bus.b_i[EXP_W+MAN_W-1 -: EXP_W];
  assign ma = bus.a_i[MAN_W-1:0];
  assign mb = bus.b_i[MAN_W-1:0];

  assign a_nan  = (&ea) & (|ma);
  assign b_nan  = (&eb) & (|mb);
  assign a_snan = a_nan & ~ma[MAN_W-1];
  assign b_snan = b_nan & ~mb[MAN_W-1];
  assign a_inf  = (&ea) & ~(|ma);
  assign b_inf  = (&eb) & ~(|mb);
  // exp == 0 covers true zero and flushed subnormals alike
  assign a_zero = ~(|ea);
  assign b_zero = ~(|eb);

  always_comb begin
    cls_n = CLS_NORM;
    inv_n = 1'b0;
    if (a_nan | b_nan) begin
      cls_n = CLS_NAN;
      inv_n = a_snan | b_snan;
    end else if ((a_inf & b_zero) | (a_zero & b_inf)) begin
      cls_n = CLS_NAN;
      inv_n = 1'b1;
    end else if (a_inf | b_inf) begin
      cls_n = CLS_INF;
    end else if (a_zero | b_zero) begin
      cls_n = CLS_ZERO;
    end
  end

  assign exp_sum_n = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
  assign prod_n    = PW'({1'b1, ma}) * PW'({1'b1, mb});

  logic                 s1_valid, s1_sign, s1_inv;
  cls_e                 s1_cls;
  logic signed [EW-1:0] s1_exp;
  logic [PW-1:0]        s1_prod;

  // ---------------- Stage 2: normalise, exponent adjust ----------------
  logic [2*MAN_W-1:0]   norm_frac;
  logic signed [EW-1:0] norm_exp;
  logic                 shift_lost;

  // Leading one sits at bit 2*MAN_W after this; anything shifted out feeds sticky.
  assign norm_frac  = s1_prod[PW-1] ? s1_prod[2*MAN_W:1] : s1_prod[2*MAN_W-1:0];
  assign norm_exp   = s1_prod[PW-1] ? s1_exp + $signed({{(EW-1){1'b0}}, 1'b1}) : s1_exp;
  assign shift_lost = s1_prod[PW-1] & s1_prod[0];

  logic                 s2_valid, s2_sign, s2_inv;
  cls_e                 s2_cls;
  logic signed [EW-1:0] s2_exp;
  logic [MAN_W-1:0]     s2_man;
  logic                 s2_guard, s2_round, s2_sticky;

  // ---------------- Stage 3: round, range check, pack ----------------
  logic                 round_up;
  logic [MAN_W:0]       man_sum;
  logic signed [EW-1:0] exp_rnd;
  logic                 inexact;
  logic [EXP_W+MAN_W:0] c_n;
  logic [3:0]           flags_n;

  assign round_up = s2_guard & (s2_round | s2_sticky | s2_man[0]);
  assign man_sum  = {1'b0, s2_man} + {{MAN_W{1'b0}}, round_up};
  // A carry out leaves man_sum[MAN_W-1:0] all zero, which is the cleared mantissa.
  assign exp_rnd  = s2_exp + $signed({{(EW-1){1'b0}}, man_sum[MAN_W]});
  assign inexact  = s2_guard | s2_round | s2_sticky;

  always_comb begin
    c_n     = '0;
    flags_n = 4'b0000;
    case (s2_cls)
      CLS_NAN: begin
        c_n     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        flags_n = {s2_inv, 3'b000};
      end
      CLS_INF:  c_n = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      CLS_ZERO: c_n = {s2_sign, {(EXP_W+MAN_W){1'b0}}};
      default: begin
        if (exp_rnd >= EXP_MAX) begin
          c_n     = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags_n = 4'b0101;
        end else if (exp_rnd <= 0) begin
          c_n     = {s2_sign, {(EXP_W+MAN_W){1'b0}}};
          flags_n = 4'b0011;
        end else begin
          c_n     = {s2_sign, exp_rnd[EXP_W-1:0], man_sum[MAN_W-1:0]};
          flags_n = {3'b000, inexact};
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid    <= 1'b0;
      s1_sign     <= 1'b0;
      s1_inv      <= 1'b0;
      s1_cls      <= CLS_ZERO;
      s1_exp      <= '0;
      s1_prod     <= '0;
      s2_valid    <= 1'b0;
      s2_sign     <= 1'b0;
      s2_inv      <= 1'b0;
      s2_cls      <= CLS_ZERO;
      s2_exp      <= '0;
      s2_man      <= '0;
      s2_guard    <= 1'b0;
      s2_round    <= 1'b0;
      s2_sticky   <= 1'b0;
      bus.valid_o <= 1'b0;
      bus.c_o     <= '0;
      bus.flags_o <= 4'b0000;
    end else if (en) begin
      s1_valid    <= bus.valid_i;
      s1_sign     <= sa ^ sb;
      s1_inv      <= inv_n;
      s1_cls      <= cls_n;
      s1_exp      <= exp_sum_n;
      s1_prod     <= prod_n;
      s2_valid    <= s1_valid;
      s2_sign     <= s1_sign;
      s2_inv      <= s1_inv;
      s2_cls      <= s1_cls;
      s2_exp      <= norm_exp;
      s2_man      <= norm_frac[2*MAN_W-1 -: MAN_W];
      s2_guard    <= norm_frac[MAN_W-1];
      s2_round    <= norm_frac[MAN_W-2];
      s2_sticky   <= (|norm_frac[MAN_W-3:0]) | shift_lost;
      bus.valid_o <= s2_valid;
      bus.c_o     <= c_n;
      bus.flags_o <= flags_n;
    end
  end
endmodule
